// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID check controller: FSM state encoding,
// sysid slave word addresses and the default expected ID/timestamp values
// (kept in step with the sysid slave generator).
package sysid_pkg;

  // FSM state encoding (plain vector constants for legacy tool flows)
  typedef logic [2:0] sysid_state_t;

  localparam sysid_state_t ST_BOOT  = 3'd0;
  localparam sysid_state_t ST_IDLE  = 3'd1;
  localparam sysid_state_t ST_RD_ID = 3'd2;
  localparam sysid_state_t ST_RD_TS = 3'd3;
  localparam sysid_state_t ST_EVAL  = 3'd4;
  localparam sysid_state_t ST_DONE  = 3'd5;

  // Word addresses inside the sysid slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Build-time values the hardware image is expected to carry
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1457613482;

  // True when both captured words equal their expected values
  function automatic logic sysid_match(
    input logic [31:0] id_word,
    input logic [31:0] ts_word,
    input logic [31:0] exp_id,
    input logic [31:0] exp_ts
  );
    return (id_word == exp_id) && (ts_word == exp_ts);
  endfunction

endpackage

// File: rtl/sysid_timeout_cnt.sv
// Up-counter with synchronous clear, increment enable and a terminal flag.
// The flag fires in the cycle where the TERMINAL-th consecutive increment is
// requested, so the owner can react on that same clock edge.
module sysid_timeout_cnt #(
  parameter int WIDTH    = 16,
  parameter int TERMINAL = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [WIDTH-1:0] TERM_M1 = WIDTH'(TERMINAL - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // Count consecutive enabled cycles; clear has priority over increment
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= {WIDTH{1'b0}};
    end else if (clear) begin
      count <= {WIDTH{1'b0}};
    end else if (inc) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign terminal = inc && (count == TERM_M1);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that reads the sysid slave (ID word, then timestamp
// word), compares both against build-time values and reports pass/fail.
// A check runs once after reset and again on each start pulse while idle.
// Optional build macro SYSID_CHECK_PERIODIC_EN: when defined, the controller
// also re-runs the check after RECHECK_PERIOD idle cycles in DONE.
module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          RECHECK_PERIOD = 1048576
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout_err
);

  // Reject parameter values the counters cannot represent
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("sysid_check_ctrl: TIMEOUT_CYCLES must be within 1..65535");
  end
  if (RECHECK_PERIOD < 1) begin : g_bad_period
    $error("sysid_check_ctrl: RECHECK_PERIOD must be at least 1");
  end

  sysid_state_t state;
  logic         accept;
  logic         stall;
  logic         launch;
  logic         timeout_tc;
  logic         idle_tc;

  // Handshake decode and check-launch request
  always_comb begin
    accept = m_read && !m_waitrequest;
    stall  = m_read && m_waitrequest;
    launch = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: launch = start || idle_tc;
      default:          launch = 1'b0;
    endcase
  end

  // Consecutive waitrequest cycles of the current read; any cycle without a
  // stall (accept, or no read outstanding) restarts the count.
  sysid_timeout_cnt #(
    .WIDTH    (16),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!stall),
    .inc      (stall),
    .terminal (timeout_tc)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam int IDLE_W = $clog2(RECHECK_PERIOD + 1);

  // Idle cycles spent in DONE; leaving DONE (any check start) clears it
  sysid_timeout_cnt #(
    .WIDTH    (IDLE_W),
    .TERMINAL (RECHECK_PERIOD)
  ) u_idle_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (state != ST_DONE),
    .inc      (state == ST_DONE),
    .terminal (idle_tc)
  );
`else
  assign idle_tc = 1'b0;
`endif

  // Check sequencer: state, Avalon command outputs and status/result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_BOOT;
      m_read      <= 1'b0;
      m_address   <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RD_ID;
          m_read      <= 1'b1;
          m_address   <= SYSID_ADDR_ID;
          busy        <= 1'b1;
          done        <= 1'b0;
          pass        <= 1'b0;
          timeout_err <= 1'b0;
        end
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            state       <= ST_RD_ID;
            m_read      <= 1'b1;
            m_address   <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
          end else begin
            state <= state;
          end
        end
        ST_RD_ID: begin
          if (timeout_tc) begin
            state       <= ST_DONE;
            m_read      <= 1'b0;
            m_address   <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (accept) begin
            id_value  <= m_readdata;
            m_address <= SYSID_ADDR_TS;
            state     <= ST_RD_TS;
          end else begin
            state <= state;
          end
        end
        ST_RD_TS: begin
          if (timeout_tc) begin
            state       <= ST_DONE;
            m_read      <= 1'b0;
            m_address   <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (accept) begin
            ts_value  <= m_readdata;
            m_read    <= 1'b0;
            m_address <= SYSID_ADDR_ID;
            state     <= ST_EVAL;
          end else begin
            state <= state;
          end
        end
        ST_EVAL: begin
          pass        <= sysid_match(id_value, ts_value, EXPECTED_ID, EXPECTED_TS);
          timeout_err <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_DONE;
        end
        default: begin
          state     <= ST_IDLE;
          m_read    <= 1'b0;
          m_address <= SYSID_ADDR_ID;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a behavioural sysid slave whose
// stall length and returned words are set per step. Expected outcomes are
// queued when a check is launched and compared when done rises.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID    = 32'd0;
  localparam logic [31:0] EXP_TS    = 32'd1457613482;
  localparam int          TIMEOUT   = 255;
  localparam int          LAT_BOUND = 400;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        timeout_err;

  // slave model configuration
  logic [31:0] slv_id = EXP_ID;
  logic [31:0] slv_ts = EXP_TS;
  int          stall_cfg = 0;
  bit          stuck = 1'b0;
  logic        stuck_addr = 1'b0;
  int          stall_cnt = 0;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    int          lat;
    int          rd0;
    int          rd1;
    int          acc;
    logic        pass;
    logic        to;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_id = 32'd0;
  logic [31:0] model_ts = 32'd0;

  sysid_check_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .id_value      (id_value),
    .ts_value      (ts_value),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  // slave: stall each read for stall_cfg cycles, or forever on stuck_addr
  always @(posedge clock) begin
    if (m_read && m_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end
  assign m_waitrequest = m_read && ((stuck && (m_address == stuck_addr)) || (stall_cnt < stall_cfg));
  assign m_readdata    = m_address ? slv_ts : slv_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model of one check: latency from launch edge, read cycles per address,
  // accepted transfers and final result registers
  task automatic push_exp(input string tag, input int stalls, input bit stuck_f, input logic st_addr);
    exp_t e;
    e.tag = tag;
    if (stuck_f) begin
      e.to   = 1'b1;
      e.pass = 1'b0;
      if (st_addr) begin
        e.lat = stalls + 1 + TIMEOUT + 1;
        e.rd0 = stalls + 1;
        e.rd1 = TIMEOUT;
        e.acc = 1;
        model_id = slv_id;
      end else begin
        e.lat = TIMEOUT + 1;
        e.rd0 = TIMEOUT;
        e.rd1 = 0;
        e.acc = 0;
      end
    end else begin
      e.lat  = 4 + 2 * stalls;
      e.rd0  = stalls + 1;
      e.rd1  = stalls + 1;
      e.acc  = 2;
      e.to   = 1'b0;
      e.pass = (slv_id == EXP_ID) && (slv_ts == EXP_TS);
      model_id = slv_id;
      model_ts = slv_ts;
    end
    e.id = model_id;
    e.ts = model_ts;
    sb_q.push_back(e);
  endtask

  // pulse start in DONE/IDLE and check the new check has begun
  task automatic launch(input string tag);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk({tag, ".done_clr"}, done, 1'b0);
    chk({tag, ".busy_set"}, busy, 1'b1);
    chk({tag, ".read_set"}, m_read, 1'b1);
  endtask

  // wait for done, pulsing start at cycle pulse_at (0 = never), then compare
  task automatic wait_done(input int pulse_at);
    exp_t e;
    int lat = 0;
    int rd0 = 0;
    int rd1 = 0;
    int acc = 0;
    e = sb_q.pop_front();
    while (lat < LAT_BOUND) begin
      @(negedge clock);
      lat++;
      start = (lat == pulse_at);
      if (m_read && !m_address) rd0++;
      if (m_read && m_address) rd1++;
      if (m_read && !m_waitrequest) acc++;
      if (done) break;
    end
    start = 1'b0;
    chk({e.tag, ".done"}, done, 1'b1);
    chk({e.tag, ".latency"}, lat, e.lat);
    chk({e.tag, ".rd_id_cycles"}, rd0, e.rd0);
    chk({e.tag, ".rd_ts_cycles"}, rd1, e.rd1);
    chk({e.tag, ".accepts"}, acc, e.acc);
    chk({e.tag, ".pass"}, pass, e.pass);
    chk({e.tag, ".timeout_err"}, timeout_err, e.to);
    chk({e.tag, ".id_value"}, id_value, e.id);
    chk({e.tag, ".ts_value"}, ts_value, e.ts);
    chk({e.tag, ".busy_clr"}, busy, 1'b0);
    chk({e.tag, ".read_low"}, m_read, 1'b0);
    repeat (3) @(negedge clock);
    chk({e.tag, ".idle_busy"}, busy, 1'b0);
    chk({e.tag, ".idle_done"}, done, 1'b1);
    chk({e.tag, ".idle_read"}, m_read, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clock);
    chk("rst.m_read", m_read, 1'b0);
    chk("rst.m_address", m_address, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.pass", pass, 1'b0);
    chk("rst.timeout_err", timeout_err, 1'b0);
    chk("rst.id_value", id_value, 32'd0);
    chk("rst.ts_value", ts_value, 32'd0);

    // automatic boot check, zero wait, matching image
    @(negedge clock);
    reset_n = 1'b1;
    push_exp("boot_ok", 0, 1'b0, 1'b0);
    wait_done(0);

    // ID mismatch
    slv_id = 32'h0000_0001;
    push_exp("id_bad", 0, 1'b0, 1'b0);
    launch("id_bad");
    wait_done(0);

    // three waitrequest cycles per read
    slv_id = EXP_ID;
    stall_cfg = 3;
    push_exp("stall3", 3, 1'b0, 1'b0);
    launch("stall3");
    wait_done(0);

    // start pulsed during RD_TS is ignored
    push_exp("start_in_ts", 3, 1'b0, 1'b0);
    launch("start_in_ts");
    wait_done(6);

    // start pulsed during EVAL is ignored
    stall_cfg = 0;
    push_exp("start_in_eval", 0, 1'b0, 1'b0);
    launch("start_in_eval");
    wait_done(3);

    // timestamp mismatch
    slv_ts = EXP_TS + 32'd1;
    push_exp("ts_bad", 0, 1'b0, 1'b0);
    launch("ts_bad");
    wait_done(0);

    // stuck on the ID read: nothing captured, old words kept
    slv_id = 32'hDEAD_BEEF;
    slv_ts = 32'hCAFE_F00D;
    stuck = 1'b1;
    stuck_addr = 1'b0;
    push_exp("to_id", 0, 1'b1, 1'b0);
    launch("to_id");
    wait_done(0);

    // stuck on the timestamp read: ID captured, old timestamp kept
    slv_id = 32'h0000_0001;
    stuck_addr = 1'b1;
    push_exp("to_ts", 0, 1'b1, 1'b1);
    launch("to_ts");
    wait_done(0);

    // clean check after a timeout clears timeout_err
    stuck = 1'b0;
    slv_id = EXP_ID;
    slv_ts = EXP_TS;
    push_exp("after_to", 0, 1'b0, 1'b0);
    launch("after_to");
    wait_done(0);

    // asynchronous reset in the middle of a stalled ID read
    stall_cfg = 50;
    launch("rst_mid");
    repeat (3) @(negedge clock);
    chk("rst_mid.in_rd_id", m_read, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid.m_read", m_read, 1'b0);
    chk("rst_mid.busy", busy, 1'b0);
    chk("rst_mid.done", done, 1'b0);
    chk("rst_mid.pass", pass, 1'b0);
    chk("rst_mid.id_value", id_value, 32'd0);
    chk("rst_mid.ts_value", ts_value, 32'd0);
    stall_cfg = 0;
    model_id = 32'd0;
    model_ts = 32'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    push_exp("reboot_ok", 0, 1'b0, 1'b0);
    wait_done(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
